piso_reg: RTL and testbench



---
 rtl/piso_reg.sv | 120 ++++++++++++
 tb/tb_piso_reg.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/piso_reg.sv
// Parallel-in serial-out shift register with valid/last framing and back-to-back frame support.
// Optional even-parity trailer bit is compiled in when PISO_PARITY_EN is defined.
module piso_reg #(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [DATA_WIDTH-1:0] pdata,
  input  logic                  pvalid,
  output logic                  pready,
  output logic                  sdata,
  output logic                  svalid,
  output logic                  slast
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;
  logic                  accept;
  logic                  load_bit;
  logic                  next_bit;
  logic [DATA_WIDTH-1:0] load_rest;
  logic [DATA_WIDTH-1:0] shift_rest;
`ifdef PISO_PARITY_EN
  logic                  parity_bit;
`endif

  // The first bit goes straight to sdata on accept, so shreg holds the remaining bits.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign load_bit   = pdata[DATA_WIDTH-1];
      assign load_rest  = {pdata[DATA_WIDTH-2:0], 1'b0};
      assign next_bit   = shreg[DATA_WIDTH-1];
      assign shift_rest = {shreg[DATA_WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign load_bit   = pdata[0];
      assign load_rest  = {1'b0, pdata[DATA_WIDTH-1:1]};
      assign next_bit   = shreg[0];
      assign shift_rest = {1'b0, shreg[DATA_WIDTH-1:1]};
    end
  endgenerate

`ifdef PISO_PARITY_EN
  assign pready = arst_n & ((state == IDLE) | (state == PARITY));
`else
  assign pready = arst_n & ((state == IDLE) | ((state == SHIFT) && (cnt == LAST)));
`endif

  assign accept = pvalid & pready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      sdata  <= 1'b0;
      svalid <= 1'b0;
      slast  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (accept) begin
      state  <= SHIFT;
      shreg  <= load_rest;
      cnt    <= '0;
      sdata  <= load_bit;
      svalid <= 1'b1;
      slast  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_bit <= ^pdata;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt == LAST) begin
`ifdef PISO_PARITY_EN
            state  <= PARITY;
            sdata  <= parity_bit;
            svalid <= 1'b1;
            slast  <= 1'b1;
`else
            state  <= IDLE;
            sdata  <= 1'b0;
            svalid <= 1'b0;
            slast  <= 1'b0;
`endif
          end else begin
            sdata  <= next_bit;
            shreg  <= shift_rest;
            cnt    <= cnt + 1'b1;
            svalid <= 1'b1;
`ifdef PISO_PARITY_EN
            slast  <= 1'b0;
`else
            // Flag the bit about to be driven if it is the final data bit.
            slast  <= (cnt == LAST - 1'b1);
`endif
          end
        end
        default: begin
          state  <= IDLE;
          sdata  <= 1'b0;
          svalid <= 1'b0;
          slast  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_reg.sv
// Directed-vector bench for piso_reg: one MSB-first and one LSB-first instance on a shared clock/reset.
// Expectations follow PISO_PARITY_EN when the bench is compiled with it.
module tb_piso_reg;

`ifdef PISO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [7:0] pdata = 8'h00;
  logic       pvalid_m = 1'b0, pvalid_l = 1'b0;
  logic       pready_m, sdata_m, svalid_m, slast_m;
  logic       pready_l, sdata_l, svalid_l, slast_l;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  piso_reg #(.DATA_WIDTH(8), .MSB_FIRST(1)) dut_m (
    .clk(clk), .arst_n(arst_n), .pdata(pdata), .pvalid(pvalid_m),
    .pready(pready_m), .sdata(sdata_m), .svalid(svalid_m), .slast(slast_m)
  );

  piso_reg #(.DATA_WIDTH(8), .MSB_FIRST(0)) dut_l (
    .clk(clk), .arst_n(arst_n), .pdata(pdata), .pvalid(pvalid_l),
    .pready(pready_l), .sdata(sdata_l), .svalid(svalid_l), .slast(slast_l)
  );

  typedef struct {
    bit         lsb;     // 1 selects the LSB-first instance
    logic [7:0] word;
    logic [7:0] seq;     // expected serial bits, leftmost sent first
    logic       par;     // expected even-parity bit
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] outs(input bit lsb);
    return lsb ? {pready_l, sdata_l, svalid_l, slast_l} : {pready_m, sdata_m, svalid_m, slast_m};
  endfunction

  // Accept a word as soon as the selected instance is ready, then check the whole frame.
  task automatic send_frame(input bit lsb, input logic [7:0] word, input logic [7:0] seq,
                            input logic par, input string tag);
    logic [3:0] o;
    logic       eb;
    int         n;
    n = 0;
    while (outs(lsb)[3] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, " ready"}, {7'd0, outs(lsb)[3]}, 8'd1);
    pdata = word;
    if (lsb) pvalid_l = 1'b1; else pvalid_m = 1'b1;
    step();
    pvalid_l = 1'b0;
    pvalid_m = 1'b0;
    pdata = ~word;
    for (int k = 0; k < FL; k++) begin
      o  = outs(lsb);
      eb = (k < 8) ? seq[7-k] : par;
      chk($sformatf("%s sdata[%0d]", tag, k), {7'd0, o[2]}, {7'd0, eb});
      chk($sformatf("%s svalid[%0d]", tag, k), {7'd0, o[1]}, 8'd1);
      chk($sformatf("%s slast[%0d]", tag, k), {7'd0, o[0]}, {7'd0, (k == FL - 1)});
      step();
    end
    o = outs(lsb);
    chk({tag, " idle svalid/sdata/slast"}, {5'd0, o[2:0]}, 8'd0);
    $display("frame %s word=%02h lsb=%0d done", tag, word, lsb);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 8'b10100101, 1'b0};
    vecs[1] = '{1'b0, 8'h3C, 8'b00111100, 1'b0};
    vecs[2] = '{1'b0, 8'h07, 8'b00000111, 1'b1};
    vecs[3] = '{1'b0, 8'h81, 8'b10000001, 1'b0};
    vecs[4] = '{1'b1, 8'h01, 8'b10000000, 1'b1};
    vecs[5] = '{1'b1, 8'hA5, 8'b10100101, 1'b0};
    vecs[6] = '{1'b1, 8'hC8, 8'b00010011, 1'b1};

    // Reset held for 100 ns
    #100;
    chk("rst outputs m", {4'd0, outs(1'b0)}, 8'd0);
    chk("rst outputs l", {4'd0, outs(1'b1)}, 8'd0);
    arst_n = 1'b1;
    step();
    chk("post-rst pready m", {7'd0, pready_m}, 8'd1);
    chk("post-rst pready l", {7'd0, pready_l}, 8'd1);
    chk("post-rst svalid m", {7'd0, svalid_m}, 8'd0);
    $display("reset check done");

    for (int i = 0; i < 7; i++)
      send_frame(vecs[i].lsb, vecs[i].word, vecs[i].seq, vecs[i].par, $sformatf("vec%0d", i));

    // Back-to-back: pvalid held high across two frames
    pdata = 8'hA5;
    pvalid_m = 1'b1;
    step();
    pdata = 8'h3C;
    for (int k = 0; k < FL; k++) begin
      chk($sformatf("b2b f1 sdata[%0d]", k), {7'd0, sdata_m},
          {7'd0, (k < 8) ? ((8'b10100101 >> (7 - k)) & 8'd1) != 0 : 1'b0});
      chk($sformatf("b2b f1 svalid[%0d]", k), {7'd0, svalid_m}, 8'd1);
      chk($sformatf("b2b f1 pready[%0d]", k), {7'd0, pready_m}, {7'd0, (k == FL - 1)});
      step();
      if (k == FL - 1) pvalid_m = 1'b0;
    end
    for (int k = 0; k < FL; k++) begin
      chk($sformatf("b2b f2 sdata[%0d]", k), {7'd0, sdata_m},
          {7'd0, (k < 8) ? ((8'b00111100 >> (7 - k)) & 8'd1) != 0 : 1'b0});
      chk($sformatf("b2b f2 svalid[%0d]", k), {7'd0, svalid_m}, 8'd1);
      chk($sformatf("b2b f2 slast[%0d]", k), {7'd0, slast_m}, {7'd0, (k == FL - 1)});
      step();
    end
    chk("b2b end svalid", {7'd0, svalid_m}, 8'd0);
    $display("back-to-back A5,3C done");

    // Reset asserted between edges in cycle N+3 of an 8'hFF frame
    pdata = 8'hFF;
    pvalid_m = 1'b1;
    step();
    pvalid_m = 1'b0;
    step();
    step();
    step();
    chk("mid svalid before rst", {7'd0, svalid_m}, 8'd1);
    chk("mid sdata before rst", {7'd0, sdata_m}, 8'd1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("mid-rst async svalid", {7'd0, svalid_m}, 8'd0);
    chk("mid-rst async sdata", {7'd0, sdata_m}, 8'd0);
    chk("mid-rst pready", {7'd0, pready_m}, 8'd0);
    step();
    step();
    #2;
    arst_n = 1'b1;
    step();
    chk("after mid-rst svalid", {7'd0, svalid_m}, 8'd0);
    $display("reset mid-frame done");
    send_frame(1'b0, 8'h81, 8'b10000001, 1'b0, "post-rst 81");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
